// File: rtl/fp_add_sequencer_if.sv
// Operand/result handshake bundle for the multi-cycle binary32 adder.
interface fp_add_sequencer_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        busy;

    // Operand source / result sink side
    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, result, busy
    );

    // Adder side
    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/fp_add_sequencer.sv
// Multi-cycle binary32 adder controller: capture/unpack, iterative alignment,
// single-cycle add/subtract, iterative normalization, pack and hold.
// Denormals flush to zero; rounding is toward zero.
module fp_add_sequencer #(
    parameter int unsigned ALIGN_STEP = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    fp_add_sequencer_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ALIGN,
        S_ADD,
        S_NORM,
        S_DONE
    } state_t;

    localparam logic [4:0] STEP = 5'(ALIGN_STEP);

    state_t             state, state_nx;
    logic               sign_x, sign_x_nx;
    logic               both_neg, both_neg_nx;
    logic               sub, sub_nx;
    logic [23:0]        mx, mx_nx;
    logic [23:0]        my, my_nx;
    logic [4:0]         d, d_nx;
    logic [24:0]        m, m_nx;
    logic signed [9:0]  ex, ex_nx;
    logic [31:0]        res, res_nx;

    // Unpack of the operands presented on the bus
    logic [7:0]  ea, eb;
    logic [22:0] fa, fb;
    logic [23:0] ma, mb;
    logic        a_is_x, a_nan, b_nan, a_inf, b_inf, special;
    logic [7:0]  exp_diff;
    logic [4:0]  d_init;

    // Datapath helpers
    logic [4:0]  shift_amt;
    logic [4:0]  d_rem;
    logic [24:0] sum;

    function automatic logic [31:0] pack(input logic s, input logic signed [9:0] e,
                                         input logic [24:0] mm);
        if (e >= 10'sd255)
            pack = {s, 8'hFF, 23'd0};
        else if (e <= 10'sd0)
            pack = {s, 31'd0};
        else
            pack = {s, e[7:0], mm[22:0]};
    endfunction

    // Operand classification, ordering and exponent difference
    always_comb begin
        ea       = bus.a[30:23];
        eb       = bus.b[30:23];
        fa       = bus.a[22:0];
        fb       = bus.b[22:0];
        ma       = (ea == 8'd0) ? '0 : {1'b1, fa};
        mb       = (eb == 8'd0) ? '0 : {1'b1, fb};
        a_is_x   = (ea > eb) || ((ea == eb) && (ma >= mb));
        a_nan    = (ea == 8'hFF) && (fa != '0);
        b_nan    = (eb == 8'hFF) && (fb != '0);
        a_inf    = (ea == 8'hFF) && (fa == '0);
        b_inf    = (eb == 8'hFF) && (fb == '0);
        special  = (ea == 8'hFF) || (eb == 8'hFF);
        exp_diff = a_is_x ? (ea - eb) : (eb - ea);
        d_init   = (exp_diff > 8'd25) ? 5'd25 : exp_diff[4:0];
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            sign_x   <= 1'b0;
            both_neg <= 1'b0;
            sub      <= 1'b0;
            mx       <= '0;
            my       <= '0;
            d        <= '0;
            m        <= '0;
            ex       <= '0;
            res      <= '0;
        end else begin
            state    <= state_nx;
            sign_x   <= sign_x_nx;
            both_neg <= both_neg_nx;
            sub      <= sub_nx;
            mx       <= mx_nx;
            my       <= my_nx;
            d        <= d_nx;
            m        <= m_nx;
            ex       <= ex_nx;
            res      <= res_nx;
        end
    end

    // Next-state and datapath sequencing
    always_comb begin
        state_nx    = state;
        sign_x_nx   = sign_x;
        both_neg_nx = both_neg;
        sub_nx      = sub;
        mx_nx       = mx;
        my_nx       = my;
        d_nx        = d;
        m_nx        = m;
        ex_nx       = ex;
        res_nx      = res;
        shift_amt   = (d > STEP) ? STEP : d;
        d_rem       = d - shift_amt;
        sum         = sub ? ({1'b0, mx} - {1'b0, my}) : ({1'b0, mx} + {1'b0, my});

        case (state)
            S_IDLE: begin
                if (bus.in_valid) begin
                    if (special) begin
                        if (a_nan || b_nan || (a_inf && b_inf && (bus.a[31] != bus.b[31])))
                            res_nx = 32'h7FC0_0000;
                        else if (a_inf)
                            res_nx = bus.a;
                        else
                            res_nx = bus.b;
                        state_nx = S_DONE;
                    end else begin
                        sign_x_nx   = a_is_x ? bus.a[31] : bus.b[31];
                        both_neg_nx = bus.a[31] & bus.b[31];
                        sub_nx      = bus.a[31] ^ bus.b[31];
                        mx_nx       = a_is_x ? ma : mb;
                        my_nx       = a_is_x ? mb : ma;
                        ex_nx       = signed'({2'b00, (a_is_x ? ea : eb)});
                        d_nx        = d_init;
                        state_nx    = S_ALIGN;
                    end
                end
            end
            S_ALIGN: begin
                my_nx = my >> shift_amt;
                d_nx  = d_rem;
                if (d_rem == 5'd0)
                    state_nx = S_ADD;
            end
            S_ADD: begin
                if (sum == '0) begin
                    res_nx   = {both_neg, 31'd0};
                    state_nx = S_DONE;
                end else begin
                    m_nx     = sum;
                    state_nx = S_NORM;
                end
            end
            S_NORM: begin
                if (m[24]) begin
                    m_nx     = m >> 1;
                    ex_nx    = ex + 10'sd1;
                    res_nx   = pack(sign_x, ex + 10'sd1, m >> 1);
                    state_nx = S_DONE;
                end else if (m[23]) begin
                    res_nx   = pack(sign_x, ex, m);
                    state_nx = S_DONE;
                end else begin
                    m_nx  = m << 1;
                    ex_nx = ex - 10'sd1;
                end
            end
            S_DONE: begin
                if (bus.out_ready)
                    state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Handshake and status outputs
    always_comb begin
        bus.in_ready  = (state == S_IDLE);
        bus.out_valid = (state == S_DONE);
        bus.busy      = (state != S_IDLE);
        bus.result    = res;
    end

endmodule
